// File: rtl/hqm_AW_pkg.sv
// Shared cfg-ring types for the AW cfg blocks.
// Request/response payloads, dispatch FSM states, timeout counter.
package hqm_AW_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
    } cfg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } cfg_rsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RSP  = 2'd2
    } cfg_tgt_state_t;

    localparam int CFG_TO_CNT_W = 16;
    typedef logic [CFG_TO_CNT_W-1:0] cfg_to_cnt_t;

    localparam int CFG_ERR_DEC = 0;
    localparam int CFG_ERR_TO  = 1;
    localparam int CFG_ERR_ACK = 2;

    localparam cfg_rsp_t CFG_RSP_ERR = '{rdata: 32'h0, err: 1'b1};

endpackage

// File: rtl/hqm_AW_cfg_addr_decode.sv
// Combinational cfg address decode: per-target mask/match.
// Produces the hit vector plus zero / one-hot / multi-hit flags.
module hqm_AW_cfg_addr_decode #(
    parameter int                     NUM_TGTS = 4,
    parameter logic [NUM_TGTS*32-1:0] TGT_MAP  = '0,
    parameter logic [NUM_TGTS*32-1:0] TGT_MSK  = '0
) (
    input  logic [31:0]         addr,
    output logic [NUM_TGTS-1:0] hit,
    output logic                hit_one,
    output logic                hit_zero,
    output logic                hit_multi
);

    // Match the masked address against every target base.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_TGTS; i++) begin
            hit[i] = (addr & TGT_MSK[i*32 +: 32])
                     == TGT_MAP[i*32 +: 32];
        end
    end

    assign hit_zero  = (hit == '0);
    assign hit_one   = $onehot(hit);
    assign hit_multi = ~hit_zero & ~hit_one;

endmodule

// File: rtl/hqm_aw_cfg_tgt_dispatch.sv
// Cfg ring dispatcher: routes one request to a decoded target,
// waits for its ack (with optional timeout) and returns a response.
module hqm_aw_cfg_tgt_dispatch
    import hqm_AW_pkg::*;
#(
    parameter int                     NUM_TGTS    = 4,
    parameter logic [NUM_TGTS*32-1:0] TGT_MAP     = '0,
    parameter logic [NUM_TGTS*32-1:0] TGT_MSK     = '0,
    parameter logic [15:0]            TIMEOUT_CYC = 16'd1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rst_prep,
    input  logic                    core_cfg_req_write,
    input  logic                    core_cfg_req_read,
    input  cfg_req_t                core_cfg_req,
    output logic                    core_cfg_rsp_ack,
    output cfg_rsp_t                core_cfg_rsp,
    output logic [NUM_TGTS-1:0]     tgt_cfg_req_write,
    output logic [NUM_TGTS-1:0]     tgt_cfg_req_read,
    output cfg_req_t                tgt_cfg_req,
    input  logic [NUM_TGTS-1:0]     tgt_cfg_rsp_ack,
    input  cfg_rsp_t [NUM_TGTS-1:0] tgt_cfg_rsp,
    output logic                    cfg_idle,
    output logic [2:0]              err_pulse
);

    cfg_tgt_state_t      state_q;
    cfg_to_cnt_t         cnt_q;
    cfg_to_cnt_t         cnt_inc;
    cfg_req_t            req_q;
    cfg_rsp_t            rsp_q;
    cfg_rsp_t            sel_rsp;
    logic [NUM_TGTS-1:0] sel_q;
    logic [NUM_TGTS-1:0] wr_q;
    logic [NUM_TGTS-1:0] rd_q;
    logic [NUM_TGTS-1:0] hit;
    logic [NUM_TGTS-1:0] wait_sel;
    logic                ack_q;
    logic [2:0]          err_q;
    logic                hit_one;
    logic                hit_zero;
    logic                hit_multi;
    logic                req_any;
    logic                dec_ok;
    logic                sel_ack;
    logic                unexp_ack;
    logic                to_hit;

    hqm_AW_cfg_addr_decode #(
        .NUM_TGTS (NUM_TGTS),
        .TGT_MAP  (TGT_MAP),
        .TGT_MSK  (TGT_MSK)
    ) u_dec (
        .addr      (core_cfg_req.addr),
        .hit       (hit),
        .hit_one   (hit_one),
        .hit_zero  (hit_zero),
        .hit_multi (hit_multi)
    );

    assign req_any = core_cfg_req_write | core_cfg_req_read;
    assign dec_ok  = hit_one & ~hit_zero & ~hit_multi
                     & (core_cfg_req_write ^ core_cfg_req_read);

    assign wait_sel  = (state_q == WAIT) ? sel_q : '0;
    assign sel_ack   = |(tgt_cfg_rsp_ack & wait_sel);
    assign unexp_ack = |(tgt_cfg_rsp_ack & ~wait_sel);

    assign cnt_inc = cnt_q + cfg_to_cnt_t'(1);
    assign to_hit  = (TIMEOUT_CYC != 16'd0)
                     && (cnt_inc == TIMEOUT_CYC);

    // Pick the response payload of the selected target.
    always_comb begin
        sel_rsp = '0;
        for (int i = 0; i < NUM_TGTS; i++) begin
            if (sel_q[i]) begin
                sel_rsp = cfg_rsp_t'(sel_rsp | tgt_cfg_rsp[i]);
            end
        end
    end

    // Request/response FSM; every output it drives is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rsp_q   <= '0;
            sel_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            wr_q               <= '0;
            rd_q               <= '0;
            err_q              <= '0;
            err_q[CFG_ERR_ACK] <= unexp_ack;
            if (rst_prep) begin
                state_q <= IDLE;
                ack_q   <= 1'b0;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (req_any) begin
                            req_q <= core_cfg_req;
                            sel_q <= hit;
                            if (dec_ok) begin
                                wr_q    <= hit & {NUM_TGTS{core_cfg_req_write}};
                                rd_q    <= hit & {NUM_TGTS{core_cfg_req_read}};
                                cnt_q   <= '0;
                                state_q <= WAIT;
                            end else begin
                                rsp_q              <= CFG_RSP_ERR;
                                ack_q              <= 1'b0;
                                err_q[CFG_ERR_DEC] <= 1'b1;
                                state_q            <= RSP;
                            end
                        end
                    end
                    WAIT: begin
                        cnt_q <= cnt_inc;
                        if (sel_ack) begin
                            rsp_q   <= sel_rsp;
                            ack_q   <= 1'b1;
                            state_q <= RSP;
                        end else if (to_hit) begin
                            rsp_q             <= CFG_RSP_ERR;
                            ack_q             <= 1'b1;
                            err_q[CFG_ERR_TO] <= 1'b1;
                            state_q           <= RSP;
                        end
                        if (req_any) begin
                            err_q[CFG_ERR_DEC] <= 1'b1;
                        end
                    end
                    RSP: begin
                        // Decode errors arrive here with ack still low:
                        // raise it one cycle later, then leave.
                        if (ack_q) begin
                            ack_q   <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            ack_q <= 1'b1;
                        end
                        if (req_any) begin
                            err_q[CFG_ERR_DEC] <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tgt_cfg_req_write = rst_prep ? '0 : wr_q;
    assign tgt_cfg_req_read  = rst_prep ? '0 : rd_q;
    assign tgt_cfg_req       = rst_prep ? '0 : req_q;
    assign core_cfg_rsp_ack  = ack_q & ~rst_prep;
    assign core_cfg_rsp      = rst_prep ? '0 : rsp_q;
    assign err_pulse         = err_q;
    assign cfg_idle          = (state_q == IDLE) & ~req_any;

endmodule

// File: tb/tb_hqm_aw_cfg_tgt_dispatch.sv
// Bench for hqm_aw_cfg_tgt_dispatch: transaction-level model plus
// literal pins on the key latencies and error cases.
module tb_hqm_aw_cfg_tgt_dispatch;
    import hqm_AW_pkg::*;

    localparam int NT = 4;
    localparam int TO = 8;
    localparam logic [NT*32-1:0] MAP =
        {32'h0400_0000, 32'h0200_0000, 32'h1100_0000, 32'h1000_0000};
    localparam logic [NT*32-1:0] MSK =
        {32'hFC00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hF000_0000};

    logic [31:0] bmap [NT] = '{32'h1000_0000, 32'h1100_0000,
                               32'h0200_0000, 32'h0400_0000};
    logic [31:0] bmsk [NT] = '{32'hF000_0000, 32'hFF00_0000,
                               32'hFF00_0000, 32'hFC00_0000};

    logic              clk = 1'b0;
    logic              rst;
    logic              rst_prep;
    logic              cwr;
    logic              crd;
    cfg_req_t          creq;
    logic              rsp_ack;
    cfg_rsp_t          rsp;
    logic [NT-1:0]     twr;
    logic [NT-1:0]     trd;
    cfg_req_t          treq;
    logic [NT-1:0]     tack;
    cfg_rsp_t [NT-1:0] trsp;
    logic              cfg_idle;
    logic [2:0]        errp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hqm_aw_cfg_tgt_dispatch #(
        .NUM_TGTS    (NT),
        .TGT_MAP     (MAP),
        .TGT_MSK     (MSK),
        .TIMEOUT_CYC (16'(TO))
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rst_prep           (rst_prep),
        .core_cfg_req_write (cwr),
        .core_cfg_req_read  (crd),
        .core_cfg_req       (creq),
        .core_cfg_rsp_ack   (rsp_ack),
        .core_cfg_rsp       (rsp),
        .tgt_cfg_req_write  (twr),
        .tgt_cfg_req_read   (trd),
        .tgt_cfg_req        (treq),
        .tgt_cfg_rsp_ack    (tack),
        .tgt_cfg_rsp        (trsp),
        .cfg_idle           (cfg_idle),
        .err_pulse          (errp)
    );

    // Transaction model: pend = target awaited, dl = timeout-ack cycle,
    // rsp_at = cycle the core ack is due (also last busy cycle).
    int          cyc    = 0;
    int          pend   = -1;
    int          dl     = 0;
    int          rsp_at = -1;
    bit          chk_en = 0;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [3:0]  e_rd;
    logic [3:0]  e_wr;
    logic [2:0]  e_errp;
    cfg_req_t    e_req;

    always @(posedge clk) begin
        int         n;
        int         nh;
        int         ht;
        bit         idle_n;
        logic [3:0] live;
        n      = cyc;
        cyc    = cyc + 1;
        e_rd   = '0;
        e_wr   = '0;
        e_errp = '0;
        idle_n = (pend < 0) && (rsp_at < n);
        if (rst) begin
            pend    = -1;
            rsp_at  = -1;
            chk_en  = 1;
            m_rdata = '0;
            m_err   = 1'b0;
        end else if (rst_prep) begin
            pend   = -1;
            rsp_at = -1;
        end else begin
            live = (pend >= 0) ? (4'b1 << pend) : 4'b0;
            if ((tack & ~live) != 0) e_errp[2] = 1'b1;
            if (pend >= 0 && tack[pend]) begin
                rsp_at  = cyc;
                m_rdata = trsp[pend].rdata;
                m_err   = trsp[pend].err;
                pend    = -1;
            end else if (pend >= 0 && cyc == dl) begin
                rsp_at    = cyc;
                m_rdata   = '0;
                m_err     = 1'b1;
                e_errp[1] = 1'b1;
                pend      = -1;
            end
            if (cwr || crd) begin
                if (!idle_n) begin
                    e_errp[0] = 1'b1;
                end else begin
                    nh = 0;
                    ht = 0;
                    for (int i = 0; i < NT; i++) begin
                        if ((creq.addr & bmsk[i]) == bmap[i]) begin
                            nh++;
                            ht = i;
                        end
                    end
                    if (nh == 1 && (cwr ^ crd)) begin
                        if (cwr) e_wr[ht] = 1'b1;
                        else     e_rd[ht] = 1'b1;
                        e_req = creq;
                        pend  = ht;
                        dl    = cyc + TO;
                    end else begin
                        e_errp[0] = 1'b1;
                        rsp_at    = cyc + 1;
                        m_rdata   = '0;
                        m_err     = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h want %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic cmp();
        logic [3:0] xr;
        logic [3:0] xw;
        logic       xa;
        logic       xi;
        if (!chk_en) return;
        xr = rst_prep ? 4'b0 : e_rd;
        xw = rst_prep ? 4'b0 : e_wr;
        xa = (rsp_at == cyc) && !rst_prep;
        xi = (pend < 0) && (rsp_at < cyc) && !cwr && !crd;
        chk("tgt_rd", 64'(trd), 64'(xr));
        chk("tgt_wr", 64'(twr), 64'(xw));
        chk("rsp_ack", 64'(rsp_ack), 64'(xa));
        chk("err_pulse", 64'(errp), 64'(e_errp));
        chk("cfg_idle", 64'(cfg_idle), 64'(xi));
        if (xa) chk("rsp", 64'(rsp), 64'({m_rdata, m_err}));
        if ((xr | xw) != 0) chk("tgt_req", 64'(treq), 64'(e_req));
    endtask

    task automatic tick();
        @(negedge clk);
        cmp();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic req(input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d);
        cwr        = w;
        crd        = r;
        creq.addr  = a;
        creq.wdata = d;
        tick();
        cwr = 1'b0;
        crd = 1'b0;
    endtask

    task automatic tgt_ack(input int t, input logic [31:0] d,
                           input logic e);
        trsp[t] = '{rdata: d, err: e};
        tack[t] = 1'b1;
        tick();
        tack = '0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        int          lat;
        int          tgt;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [4] = '{
        '{32'h1200_0000, 1'b1, 0, 0, 32'h0000_1111},
        '{32'h0400_1234, 1'b0, 3, 3, 32'h3456_7890},
        '{32'h0200_FFFC, 1'b1, 1, 2, 32'hCAFE_0002},
        '{32'h07FF_FFFC, 1'b0, 5, 3, 32'hDEAD_BEEF}
    };

    initial begin
        rst      = 1'b1;
        rst_prep = 1'b0;
        cwr      = 1'b0;
        crd      = 1'b0;
        creq     = '0;
        tack     = '0;
        trsp     = '0;
        idle(3);
        rst = 1'b0;
        chk("reset_idle", 64'(cfg_idle), 64'd1);
        chk("reset_ack", 64'(rsp_ack), 64'd0);
        chk("reset_errp", 64'(errp), 64'd0);
        chk("reset_tgt", 64'({trd, twr}), 64'd0);
        idle(2);

        // read to target 2, ack four cycles after the tgt req
        req(1'b0, 1'b1, 32'h0200_0010, 32'h0);
        chk("s1_tgt_rd", 64'(trd), 64'h4);
        chk("s1_busy", 64'(cfg_idle), 64'd0);
        idle(4);
        tgt_ack(2, 32'hA5A5_0001, 1'b0);
        chk("s1_ack", 64'(rsp_ack), 64'd1);
        chk("s1_rdata", 64'(rsp.rdata), 64'hA5A5_0001);
        chk("s1_err", 64'(rsp.err), 64'd0);
        tick();
        chk("s1_ack_once", 64'(rsp_ack), 64'd0);
        chk("s1_idle", 64'(cfg_idle), 64'd1);

        foreach (vecs[i]) begin
            req(vecs[i].wr, ~vecs[i].wr, vecs[i].addr, 32'h5A00_0000 + i);
            idle(vecs[i].lat);
            tgt_ack(vecs[i].tgt, vecs[i].rdata, 1'b0);
            idle(2);
        end

        // no-hit write
        req(1'b1, 1'b0, 32'h7700_0000, 32'h1234_5678);
        chk("nohit_tgt", 64'({twr, trd}), 64'd0);
        chk("nohit_errp", 64'(errp), 64'd1);
        chk("nohit_ack_n1", 64'(rsp_ack), 64'd0);
        tick();
        chk("nohit_ack_n2", 64'(rsp_ack), 64'd1);
        chk("nohit_rsp", 64'(rsp), 64'({32'h0, 1'b1}));
        idle(2);
        // multi-hit, and write+read together
        req(1'b0, 1'b1, 32'h1100_0000, 32'h0);
        chk("multi_errp", 64'(errp), 64'd1);
        idle(3);
        req(1'b1, 1'b1, 32'h0200_0000, 32'h0);
        chk("wrrd_errp", 64'(errp), 64'd1);
        chk("wrrd_tgt", 64'({twr, trd}), 64'd0);
        idle(3);

        // timeout, then a late ack
        req(1'b0, 1'b1, 32'h0400_0000, 32'h0);
        idle(7);
        chk("to_early", 64'(rsp_ack), 64'd0);
        tick();
        chk("to_ack", 64'(rsp_ack), 64'd1);
        chk("to_err", 64'(rsp.err), 64'd1);
        chk("to_errp", 64'(errp), 64'd2);
        tick();
        tgt_ack(3, 32'h0BAD_0BAD, 1'b0);
        chk("late_errp", 64'(errp), 64'd4);
        chk("late_noack", 64'(rsp_ack), 64'd0);
        idle(2);

        // wrong target acks first
        req(1'b0, 1'b1, 32'h0500_0000, 32'h0);
        tick();
        tgt_ack(1, 32'h1111_1111, 1'b0);
        chk("wrong_errp", 64'(errp), 64'd4);
        chk("wrong_noack", 64'(rsp_ack), 64'd0);
        tgt_ack(3, 32'h3333_0003, 1'b1);
        chk("right_ack", 64'(rsp_ack), 64'd1);
        chk("right_rsp", 64'(rsp), 64'({32'h3333_0003, 1'b1}));
        idle(2);

        // ack lands on the timeout cycle
        req(1'b0, 1'b1, 32'h0200_0040, 32'h0);
        idle(7);
        tgt_ack(2, 32'hBEEF_0002, 1'b0);
        chk("race_ack", 64'(rsp_ack), 64'd1);
        chk("race_rdata", 64'(rsp.rdata), 64'hBEEF_0002);
        chk("race_errp", 64'(errp), 64'd0);
        idle(2);

        // second request while waiting
        req(1'b0, 1'b1, 32'h0200_0000, 32'h0);
        req(1'b1, 1'b0, 32'h1200_0000, 32'h0);
        chk("drop_errp", 64'(errp), 64'd1);
        chk("drop_tgt", 64'(twr), 64'd0);
        tgt_ack(2, 32'h0000_2222, 1'b0);
        chk("drop_ack", 64'(rsp_ack), 64'd1);
        idle(2);

        // reset during WAIT
        req(1'b0, 1'b1, 32'h0200_0000, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_idle", 64'(cfg_idle), 64'd1);
        chk("rstw_ack", 64'(rsp_ack), 64'd0);
        idle(2);
        tgt_ack(2, 32'h0000_3333, 1'b0);
        chk("rstw_late", 64'(errp), 64'd4);
        idle(2);

        // rst_prep during a decode-error RSP
        req(1'b1, 1'b0, 32'h7700_0000, 32'h0);
        rst_prep = 1'b1;
        tick();
        rst_prep = 1'b0;
        chk("prep_noack", 64'(rsp_ack), 64'd0);
        chk("prep_idle", 64'(cfg_idle), 64'd1);
        idle(3);
        // rst_prep on the ack cycle of a target response
        req(1'b0, 1'b1, 32'h0200_0000, 32'h0);
        tick();
        tgt_ack(2, 32'h4444_4444, 1'b0);
        rst_prep = 1'b1;
        #1;
        chk("prep_mask_ack", 64'(rsp_ack), 64'd0);
        chk("prep_mask_rsp", 64'(rsp), 64'd0);
        tick();
        rst_prep = 1'b0;
        chk("prep2_idle", 64'(cfg_idle), 64'd1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hqm_aw_cfg_tgt_dispatch.md
HQM_AW_CFG_TGT_DISPATCH -- requirements
Module: hqm_AW_cfg_tgt_dispatch

Interface
REQ-001 Parameter NUM_TGTS, default 4: number of downstream cfg targets, range 1..16.
REQ-002 Parameter TGT_MAP, default '0: packed NUM_TGTS x 32-bit base addresses, one per target.
REQ-003 Parameter TGT_MSK, default '0: packed NUM_TGTS x 32-bit address-match masks, one per target.
REQ-004 Parameter TIMEOUT_CYC, default 1024: 16-bit response timeout in cycles; 0 disables the timeout.
REQ-005 clk  in  1  sole clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rst_prep  in  1  reset-preparation gate.
REQ-008 core_cfg_req_write / core_cfg_req_read  in  1 each  single-cycle request pulses from the ring element.
REQ-009 core_cfg_req  in  cfg_req_t  request payload; addr field is 32 bits.
REQ-010 core_cfg_rsp_ack  out  1  single-cycle response pulse.
REQ-011 core_cfg_rsp  out  cfg_rsp_t  response payload, fields rdata[31:0] and err.
REQ-012 tgt_cfg_req_write / tgt_cfg_req_read  out  NUM_TGTS  one-hot request pulses.
REQ-013 tgt_cfg_req  out  cfg_req_t  request payload, broadcast to all targets.
REQ-014 tgt_cfg_rsp_ack  in  NUM_TGTS  per-target response pulses.
REQ-015 tgt_cfg_rsp  in  NUM_TGTS x cfg_rsp_t  per-target response payloads.
REQ-016 cfg_idle  out  1  high when the block holds no request.
REQ-017 err_pulse  out  3  one-cycle pulses for [0] decode error, [1] timeout, [2] unexpected ack.

Function
REQ-018 Decode: target i hits when (core_cfg_req.addr & TGT_MSK[i]) == TGT_MAP[i].
REQ-019 The FSM SHALL have three states: IDLE, WAIT and RSP.
REQ-020 IDLE: on a request pulse, register the payload and the hit vector. Exactly one hit, with only one of write/read set: pulse the matching tgt req at cycle N+1 and go to WAIT. Otherwise: go to RSP with err=1 and rdata=0, and pulse err_pulse[0].
REQ-021 WAIT: the counter increments each cycle. An ack from the selected target captures that target's tgt_cfg_rsp and moves to RSP. If TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC, go to RSP with err=1 and rdata=0, and pulse err_pulse[1].
REQ-022 RSP: drive core_cfg_rsp_ack=1 with the captured response for exactly one cycle, then return to IDLE.
REQ-023 Latency: a target ack at cycle M produces core_cfg_rsp_ack at cycle M+1. A decode error produces the ack at N+2 after request cycle N.
REQ-024 An ack from a non-selected target, or any ack outside WAIT (including late acks after a timeout), SHALL be ignored and SHALL pulse err_pulse[2].
REQ-025 An ack in the same cycle as the timeout match SHALL win: the real response is returned and no timeout is flagged.
REQ-026 A request pulse outside IDLE SHALL be dropped (upstream guarantees one outstanding request) and SHALL pulse err_pulse[0].
REQ-027 cfg_idle = (state==IDLE) & ~core_cfg_req_write & ~core_cfg_req_read.
REQ-028 While rst_prep=1: tgt req outputs, core_cfg_rsp_ack and core_cfg_rsp SHALL be forced to 0, and the FSM SHALL return to IDLE on the next clock.

Reset
REQ-029 While rst=1, at the clock edge: state=IDLE, counter=0, all registered outputs 0, and captured response 0.
REQ-030 rst asserted mid-transaction SHALL abandon the transaction without producing any ack.

Structure
REQ-031 cfg_req_t and cfg_rsp_t SHALL come from hqm_AW_pkg.
REQ-032 The FSM state enum and the timeout-counter width SHALL be added to hqm_AW_pkg.
REQ-033 One sub-module, hqm_AW_cfg_addr_decode, SHALL be used: combinational mask/match producing the hit vector and the one-hot/zero/multi flags.

Verification
REQ-034 NUM_TGTS=4, TGT_MAP[2]=0x0200_0000, MSK=0xFF00_0000; read of 0x0200_0010 at cycle 10 -> tgt_cfg_req_read=4'b0100 at cycle 11; tgt ack[2] with rdata=0xA5A5_0001 at cycle 15 -> core ack at cycle 16 with rdata 0xA5A5_0001, err=0.
REQ-035 Write to 0x7700_0000 (no hit) at cycle N -> no tgt req; core ack at N+2 with err=1; err_pulse[0] asserted.
REQ-036 TIMEOUT_CYC=8, target never acks -> core ack with err=1 eight cycles after WAIT entry; a later ack from that target -> err_pulse[2] asserted, no core ack.
REQ-037 Ack from target 1 while target 3 is selected -> ignored with err_pulse[2]; a later ack from target 3 completes normally.
REQ-038 rst asserted during WAIT, or rst_prep asserted during RSP -> no core_cfg_rsp_ack emitted; cfg_idle=1 after one cycle.
